sbox_layer: RTL and testbench



---
 rtl/sbox_pkg.sv | 11 +
 rtl/sbox_layer_if.sv | 22 ++
 rtl/sbox_lut.sv | 10 +
 rtl/sbox_layer.sv | 91 +++++++++
 tb/tb_sbox_layer.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/sbox_pkg.sv
// rtl/sbox_pkg.sv - shared types and constants for the nibble substitution layer
package sbox_pkg;

   localparam int SBOX_W = 4;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   // Entry i sits at bits [4i+3:4i]; the table is its own inverse.
   localparam logic [15:0][SBOX_W-1:0] SBOX_DEFAULT = 64'h1247_8A9B_C63D_5EF0;

endpackage

// File: rtl/sbox_layer_if.sv
// rtl/sbox_layer_if.sv - valid/ready word handshakes on both sides of the substitution layer
interface sbox_layer_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_bypass;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport slave (
      input  in_valid, in_data, in_bypass, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, in_bypass, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/sbox_lut.sv
// rtl/sbox_lut.sv - combinational lookup of one nibble in a flattened 16-entry table
module sbox_lut
   import sbox_pkg::*;
(
   input  logic [16*SBOX_W-1:0] tbl,
   input  logic [SBOX_W-1:0]    idx,
   output logic [SBOX_W-1:0]    q
);
   assign q = tbl[{idx, 2'b00} +: SBOX_W];
endmodule

// File: rtl/sbox_layer.sv
// rtl/sbox_layer.sv - multi-cycle S-box layer, LANES nibbles per beat, runtime-writable table
module sbox_layer
   import sbox_pkg::*;
#(
   parameter int NUM_SBOX = 8,
   parameter int LANES    = 2
) (
   input  logic        clk,
   input  logic        rst,
   sbox_layer_if.slave bus,
   input  logic        tbl_we,
   input  logic [3:0]  tbl_addr,
   input  logic [3:0]  tbl_data,
   output logic        tbl_err
);
   localparam int BEATS = NUM_SBOX / LANES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IDX_W = (NUM_SBOX > 1) ? $clog2(NUM_SBOX) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

   generate
      if (LANES < 1 || (NUM_SBOX % LANES) != 0) begin : g_bad_lanes
         $error("sbox_layer: LANES must divide NUM_SBOX");
      end
   endgenerate

   state_t                            state;
   logic [CNT_W-1:0]                  cnt;
   logic                              bypass_q;
   logic [NUM_SBOX-1:0][SBOX_W-1:0]   work;
   logic [15:0][SBOX_W-1:0]           tbl;
   logic [LANES-1:0][IDX_W-1:0]       lane_idx;
   logic [LANES-1:0][SBOX_W-1:0]      lane_sub;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_idx[l] = IDX_W'(int'(cnt) * LANES + l);
      sbox_lut u_lut (
         .tbl (tbl),
         .idx (work[lane_idx[l]]),
         .q   (lane_sub[l])
      );
   end

   assign bus.out_data = work;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         work          <= '0;
         cnt           <= '0;
         bypass_q      <= 1'b0;
         tbl           <= SBOX_DEFAULT;
         tbl_err       <= 1'b0;
      end else begin
         tbl_err <= tbl_we && (state != IDLE);
         case (state)
            IDLE: begin
               // A write landing with an accept is visible from the first beat.
               if (tbl_we) tbl[tbl_addr] <= tbl_data;
               if (bus.in_valid) begin
                  work         <= bus.in_data;
                  bypass_q     <= bus.in_bypass;
                  cnt          <= '0;
                  state        <= BUSY;
                  bus.in_ready <= 1'b0;
               end
            end
            BUSY: begin
               if (!bypass_q) begin
                  for (int l = 0; l < LANES; l++) work[lane_idx[l]] <= lane_sub[l];
               end
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state         <= DONE;
                  bus.out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state         <= IDLE;
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sbox_layer.sv
// tb/tb_sbox_layer.sv - directed-vector bench for sbox_layer
module tb_sbox_layer;
   logic       clk = 1'b0;
   logic       rst;
   logic       tbl_we;
   logic [3:0] tbl_addr;
   logic [3:0] tbl_data;
   logic       tbl_err;
   int         n_tests = 0;
   int         n_fail  = 0;

   sbox_layer_if #(.DATA_W(32)) bus ();

   sbox_layer #(.NUM_SBOX(8), .LANES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .tbl_we   (tbl_we),
      .tbl_addr (tbl_addr),
      .tbl_data (tbl_data),
      .tbl_err  (tbl_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [31:0] data, input logic byp, input logic we,
                         input logic [3:0] addr, input logic [3:0] val);
      int n = 0;
      while (!bus.in_ready && n < 20) begin
         tick();
         n++;
      end
      check("accept_ready", {31'b0, bus.in_ready}, 32'd1);
      bus.in_valid  = 1'b1;
      bus.in_data   = data;
      bus.in_bypass = byp;
      tbl_we = we; tbl_addr = addr; tbl_data = val;
      tick();
      bus.in_valid = 1'b0;
      tbl_we = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic handshake();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic run_word(input string tag, input logic [31:0] data, input logic byp,
                           input logic [31:0] exp);
      int lat;
      accept(data, byp, 1'b0, 4'h0, 4'h0);
      wait_valid(lat);
      check({tag, "_lat"}, lat, 32'd4);
      check({tag, "_data"}, bus.out_data, exp);
      handshake();
   endtask

   task automatic tbl_write(input logic [3:0] addr, input logic [3:0] val);
      tbl_we = 1'b1; tbl_addr = addr; tbl_data = val;
      tick();
      tbl_we = 1'b0;
   endtask

   initial begin
      int lat;
      rst = 1'b1;
      tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_bypass = 1'b0; bus.out_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst_out_data", bus.out_data, 32'h0);
      check("rst_tbl_err", {31'b0, tbl_err}, 32'd0);

      run_word("w0", 32'h0123_4567, 1'b0, 32'h0FE5_D36C);
      run_word("w1", 32'h89AB_CDEF, 1'b0, 32'hB9A8_7421);
      run_word("w1_inv", 32'hB9A8_7421, 1'b0, 32'h89AB_CDEF);
      run_word("bypass", 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);

      tbl_write(4'h0, 4'h7);
      run_word("wr_idle", 32'h0000_0000, 1'b0, 32'h7777_7777);
      tbl_write(4'h0, 4'h0);
      accept(32'h0000_0010, 1'b0, 1'b1, 4'h0, 4'h7);
      wait_valid(lat);
      check("wr_same_lat", lat, 32'd4);
      check("wr_same_data", bus.out_data, 32'h7777_77F7);
      handshake();
      tbl_write(4'h0, 4'h0);

      // Back-pressure: result held, extra input ignored
      accept(32'h0123_4567, 1'b0, 1'b0, 4'h0, 4'h0);
      wait_valid(lat);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_data", bus.out_data, 32'h0FE5_D36C);
         check("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
         check("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
      end
      bus.in_valid = 1'b0;
      handshake();
      tick();
      check("hold_no_capture", {31'b0, bus.out_valid}, 32'd0);
      check("hold_idle_ready", {31'b0, bus.in_ready}, 32'd1);

      // Table write while busy is rejected
      accept(32'h0000_0000, 1'b0, 1'b0, 4'h0, 4'h0);
      tbl_write(4'h0, 4'h7);
      check("err_pulse", {31'b0, tbl_err}, 32'd1);
      tick();
      check("err_clear", {31'b0, tbl_err}, 32'd0);
      wait_valid(lat);
      check("err_data", bus.out_data, 32'h0000_0000);
      handshake();
      run_word("err_after", 32'h0123_4567, 1'b0, 32'h0FE5_D36C);

      // Reset during BUSY aborts word and restores table
      tbl_write(4'h0, 4'h7);
      accept(32'h0000_0000, 1'b0, 1'b0, 4'h0, 4'h0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      check("mrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      repeat (5) tick();
      check("mrst_no_output", {31'b0, bus.out_valid}, 32'd0);
      run_word("mrst_tbl", 32'h0000_0000, 1'b0, 32'h0000_0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
